// File: rtl/dcr_bank.sv
`default_nettype none
// ============================================================================
// Module  : dcr_bank
// Purpose : Double-buffered device control register bank that owns the
//           kernel launch handshake (start / busy / done / error).
// Revision: 1.0 - initial release
// ============================================================================
module dcr_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CFG    = 4,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          device_control_write_enable,
    input  logic                          device_control_read_enable,
    input  logic [ADDR_WIDTH-1:0]         device_control_addr,
    input  logic [DATA_WIDTH-1:0]         device_control_data,
    output logic [DATA_WIDTH-1:0]         device_control_rdata,
    output logic                          device_control_rvalid,
    output logic [DATA_WIDTH-1:0]         thread_count,
    output logic [NUM_CFG*DATA_WIDTH-1:0] cfg_flat,
    output logic                          kernel_start,
    input  logic                          kernel_done,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam logic [ADDR_WIDTH-1:0] c_addr_ctrl   = ADDR_WIDTH'(NUM_CFG);
    localparam logic [ADDR_WIDTH-1:0] c_addr_status = ADDR_WIDTH'(NUM_CFG + 1);

    generate
        if (NUM_CFG < 1 || DATA_WIDTH < 3 || (2 ** ADDR_WIDTH) < (NUM_CFG + 2)) begin : g_param_check
            $error("dcr_bank: illegal NUM_CFG / ADDR_WIDTH / DATA_WIDTH combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_stage  [NUM_CFG];
    logic [DATA_WIDTH-1:0] r_shadow [NUM_CFG];
    logic                  r_error;
    logic                  r_kernel_start;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    logic                  w_ctrl_wr;
    logic                  w_start;
    logic                  w_clear;
    logic                  w_cfg0_zero;
    logic                  w_error_next;
    logic [DATA_WIDTH-1:0] w_rd_value;

    assign w_ctrl_wr   = device_control_write_enable && (device_control_addr == c_addr_ctrl);
    assign w_start     = w_ctrl_wr && device_control_data[0];
    assign w_clear     = w_ctrl_wr && device_control_data[1];
    assign w_cfg0_zero = (r_stage[0] == '0);

    // Clear is applied first, so a combined clear+start can still flag a new error.
    always_comb begin
        w_error_next = r_error;
        if (w_clear) begin
            w_error_next = 1'b0;
        end
        if (w_start && ((r_state == S_BUSY) || w_cfg0_zero)) begin
            w_error_next = 1'b1;
        end
    end

    // Read mux works on pre-write register contents.
    always_comb begin
        w_rd_value = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (device_control_addr == ADDR_WIDTH'(i)) begin
                w_rd_value = r_stage[i];
            end
        end
        if (device_control_addr == c_addr_status) begin
            w_rd_value = {{(DATA_WIDTH-3){1'b0}}, r_error, (r_state == S_DONE), (r_state == S_BUSY)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                r_stage[i] <= '0;
            end
        end else if (device_control_write_enable) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (device_control_addr == ADDR_WIDTH'(i)) begin
                    r_stage[i] <= device_control_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= device_control_read_enable;
            if (device_control_read_enable) begin
                r_rdata <= w_rd_value;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_error        <= 1'b0;
            r_kernel_start <= 1'b0;
            for (int i = 0; i < NUM_CFG; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_error        <= w_error_next;
            r_kernel_start <= 1'b0;
            case (r_state)
                S_BUSY: begin
                    if (kernel_done) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    if (w_start) begin
                        if (!w_cfg0_zero) begin
                            r_state        <= S_BUSY;
                            r_kernel_start <= 1'b1;
                            for (int i = 0; i < NUM_CFG; i++) begin
                                r_shadow[i] <= r_stage[i];
                            end
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_clear) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_CFG; g++) begin : g_flat
            assign cfg_flat[g*DATA_WIDTH +: DATA_WIDTH] = r_shadow[g];
        end
    endgenerate

    assign thread_count          = r_shadow[0];
    assign kernel_start          = r_kernel_start;
    assign busy                  = (r_state == S_BUSY);
    assign done                  = (r_state == S_DONE);
    assign error                 = r_error;
    assign device_control_rdata  = r_rdata;
    assign device_control_rvalid = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_dcr_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_dcr_bank
// Purpose : Randomised and directed scoreboard bench for dcr_bank.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dcr_bank;

    localparam int c_dw = 16;
    localparam int c_n  = 4;
    localparam int c_aw = 3;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  we = 1'b0;
    logic                  re = 1'b0;
    logic [c_aw-1:0]       addr = '0;
    logic [c_dw-1:0]       wdata = '0;
    logic [c_dw-1:0]       rdata;
    logic                  rvalid;
    logic [c_dw-1:0]       thread_count;
    logic [c_n*c_dw-1:0]   cfg_flat;
    logic                  kernel_start;
    logic                  kernel_done = 1'b0;
    logic                  busy, done, error;

    dcr_bank #(.DATA_WIDTH(c_dw), .NUM_CFG(c_n), .ADDR_WIDTH(c_aw)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .device_control_write_enable (we),
        .device_control_read_enable  (re),
        .device_control_addr         (addr),
        .device_control_data         (wdata),
        .device_control_rdata        (rdata),
        .device_control_rvalid       (rvalid),
        .thread_count                (thread_count),
        .cfg_flat                    (cfg_flat),
        .kernel_start                (kernel_start),
        .kernel_done                 (kernel_done),
        .busy                        (busy),
        .done                        (done),
        .error                       (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [c_dw-1:0] data;
        int              cyc;
    } rd_t;

    rd_t               rq[$];
    logic [c_n*c_dw-1:0] lq[$];

    // Reference model: plain register arrays plus three status flags.
    logic [c_dw-1:0] m_stage  [c_n];
    logic [c_dw-1:0] m_shadow [c_n];
    bit              m_busy, m_done, m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [c_n*c_dw-1:0] m_flat();
        logic [c_n*c_dw-1:0] f;
        for (int i = 0; i < c_n; i++) f[i*c_dw +: c_dw] = m_shadow[i];
        return f;
    endfunction

    function automatic void model_step(input bit w, input bit r, input int a,
                                       input logic [c_dw-1:0] d, input bit kd, input bit rs);
        bit start, clear;
        rd_t e;
        if (rs) begin
            for (int i = 0; i < c_n; i++) begin
                m_stage[i]  = '0;
                m_shadow[i] = '0;
            end
            m_busy = 0; m_done = 0; m_err = 0;
            return;
        end
        if (r) begin
            if (a < c_n)           e.data = m_stage[a];
            else if (a == c_n + 1) e.data = c_dw'({m_err, m_done, m_busy});
            else                   e.data = '0;
            e.cyc = cyc + 1;
            rq.push_back(e);
        end
        start = w && (a == c_n) && d[0];
        clear = w && (a == c_n) && d[1];
        if (clear) begin
            m_err = 0;
            m_done = 0;
        end
        if (m_busy) begin
            if (start) m_err = 1;
            if (kd) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (start) begin
            m_done = 0;
            if (m_stage[0] != 0) begin
                for (int i = 0; i < c_n; i++) m_shadow[i] = m_stage[i];
                m_busy = 1;
                lq.push_back(m_flat());
            end else begin
                m_err = 1;
            end
        end
        if (w && a < c_n) m_stage[a] = d;
    endfunction

    task automatic step(input bit w, input bit r, input int a, input logic [c_dw-1:0] d,
                        input bit kd = 0, input bit rs = 0);
        @(negedge clk);
        we = w; re = r; addr = c_aw'(a); wdata = d; kernel_done = kd; reset = rs;
        model_step(w, r, a, d, kd, rs);
        @(posedge clk);
        #1;
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("error", 64'(error), 64'(m_err));
        chk("thread_count", 64'(thread_count), 64'(m_shadow[0]));
        chk("cfg_flat", 64'(cfg_flat), 64'(m_flat()));
    endtask

    // Monitor: pops expected responses whenever the DUT presents one.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (rq.size() == 0) begin
                chk("rvalid_unexpected", 64'(1), 64'(0));
            end else begin
                rd_t e;
                e = rq.pop_front();
                chk("rdata", 64'(rdata), 64'(e.data));
                chk("rvalid_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (rq.size() != 0 && rq[0].cyc < cyc) begin
            void'(rq.pop_front());
            chk("rvalid_missing", 64'(0), 64'(1));
        end
        if (kernel_start === 1'b1) begin
            if (lq.size() == 0) begin
                chk("kernel_start_unexpected", 64'(1), 64'(0));
            end else begin
                chk("launch_cfg", 64'(cfg_flat), 64'(lq.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < c_n; i++) begin
            m_stage[i] = '0;
            m_shadow[i] = '0;
        end
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        for (int a = 0; a < 8; a++) step(0, 1, a, 16'hFFFF);

        // First launch
        step(1, 0, 0, 16'h0020);
        step(1, 0, 3, 16'hBEEF);
        step(1, 0, c_n, 16'h0001);
        step(0, 1, c_n + 1, 0);
        chk("cfg3_shadow", 64'(cfg_flat[63:48]), 64'(16'hBEEF));

        // Start while busy, then completion and clear
        step(1, 0, 0, 16'h0040);
        step(1, 0, c_n, 16'h0001);
        step(0, 0, 0, 0, 1);
        step(0, 1, c_n + 1, 0);
        step(1, 0, c_n, 16'h0002);
        step(0, 1, c_n + 1, 0);

        // Start with zero thread count
        step(1, 0, 0, 16'h0000);
        step(1, 0, c_n, 16'h0001);
        step(0, 1, c_n + 1, 0);
        step(1, 0, c_n, 16'h0002);

        // Back-to-back kernels, then reset mid-busy
        step(1, 0, 0, 16'h0005);
        step(1, 0, c_n, 16'h0001);
        step(1, 0, 2, 16'h0077);
        step(0, 0, 0, 0, 1);
        step(1, 0, c_n, 16'h0003);
        step(0, 1, c_n + 1, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, c_n + 1, 0);

        // Same-cycle read/write and dropped write to an unmapped address
        step(1, 0, 1, 16'h1111);
        step(1, 1, 1, 16'h2222);
        step(0, 1, 1, 0);
        step(1, 0, 7, 16'hFFFF);
        step(1, 0, c_n + 1, 16'hFFFF);
        for (int a = 0; a < 8; a++) step(0, 1, a, 0);

        for (int k = 0; k < 3000; k++) begin
            bit w, r, kd, rs;
            int a;
            logic [c_dw-1:0] d;
            w  = ($urandom_range(0, 2) != 0);
            r  = ($urandom_range(0, 2) == 0);
            a  = $urandom_range(0, 7);
            d  = ($urandom_range(0, 3) == 0) ? 16'h0000 : c_dw'($urandom);
            if (a == c_n && $urandom_range(0, 1) == 0) d = c_dw'($urandom_range(1, 3));
            kd = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 99) == 0);
            step(w, r, a, d, kd, rs);
        end

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("reads_drained", 64'(rq.size()), 64'(0));
        chk("launches_drained", 64'(lq.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
